// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sound_pkg
// Brief    : Shared types and register map for the sound block bus interface.
// Revision : 1.0
// ============================================================================
package sound_pkg;

    localparam logic [15:0] POKEY_BZ_BASE = 16'h1820;
    localparam logic [15:0] POKEY_RB_BASE = 16'h1810;
    localparam logic [15:0] OUT_LATCH_BZ  = 16'h1840;
    localparam logic [15:0] OUT_LATCH_RB  = 16'h1808;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } snd_bus_req_t;

    typedef enum logic [2:0] {
        SB_IDLE   = 3'd0,
        SB_SETUP  = 3'd1,
        SB_STROBE = 3'd2,
        SB_SAMPLE = 3'd3,
        SB_HOLD   = 3'd4
    } snd_bus_state_t;

endpackage
`default_nettype wire

// File: rtl/sound_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sound_req_fifo
// Brief    : Request queue for the sound bus master; extra pointer bit
//            distinguishes full from empty.
// Revision : 1.0
// ============================================================================
module sound_req_fifo
    import sound_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  snd_bus_req_t push_data,
    input  logic         pop,
    output snd_bus_req_t head,
    output logic         full,
    output logic         empty
);

    localparam int            c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = 1;

    snd_bus_req_t    r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Storage needs no reset: pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

    assign head = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/sound_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : sound_bus_master
// Brief    : Queues producer requests and replays them as 3 MHz-paced bus
//            cycles toward the sound block, returning read data in order.
// Revision : 1.0
// ============================================================================
module sound_bus_master
    import sound_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] IDLE_ADDR = 16'hFFFF
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_3MHz_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic [15:0] addr_to_bram,
    output logic [7:0]  data_to_bram,
    output logic        should_read,
    input  logic [7:0]  data_from_bram
);

    snd_bus_state_t r_state;
    snd_bus_state_t w_state_nxt;
    logic           r_cur_write;
    logic           w_cur_write_nxt;
    logic [15:0]    w_addr_nxt;
    logic [7:0]     w_data_nxt;
    logic           w_sr_nxt;
    logic           w_capture;
    logic           w_pop;
    logic           w_push;
    logic           w_full;
    logic           w_empty;
    snd_bus_req_t   w_push_data;
    snd_bus_req_t   w_head;

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign req_ready = rst & ~w_full;
    assign w_push    = req_valid & req_ready;

    assign w_push_data.write = req_write;
    assign w_push_data.addr  = req_addr;
    assign w_push_data.wdata = req_wdata;

    sound_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign busy = ~w_empty | (r_state != SB_IDLE);

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_write_nxt = r_cur_write;
        w_addr_nxt      = addr_to_bram;
        w_data_nxt      = data_to_bram;
        w_sr_nxt        = should_read;
        w_capture       = 1'b0;
        w_pop           = 1'b0;
        if (clk_3MHz_en) begin
            case (r_state)
                SB_IDLE: begin
                    if (!w_empty) begin
                        w_pop           = 1'b1;
                        w_addr_nxt      = w_head.addr;
                        w_data_nxt      = w_head.write ? w_head.wdata : 8'h00;
                        w_cur_write_nxt = w_head.write;
                        w_state_nxt     = SB_SETUP;
                    end
                end
                SB_SETUP: begin
                    if (r_cur_write) begin
                        w_sr_nxt    = 1'b1;
                        w_state_nxt = SB_STROBE;
                    end else begin
                        w_state_nxt = SB_SAMPLE;
                    end
                end
                SB_STROBE: begin
                    w_sr_nxt    = 1'b0;
                    w_state_nxt = SB_HOLD;
                end
                SB_SAMPLE: begin
                    w_capture   = 1'b1;
                    w_state_nxt = SB_HOLD;
                end
                SB_HOLD: begin
                    w_addr_nxt  = IDLE_ADDR;
                    w_data_nxt  = 8'h00;
                    w_state_nxt = SB_IDLE;
                end
                default: begin
                    w_addr_nxt  = IDLE_ADDR;
                    w_data_nxt  = 8'h00;
                    w_sr_nxt    = 1'b0;
                    w_state_nxt = SB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= SB_IDLE;
            r_cur_write  <= 1'b0;
            addr_to_bram <= IDLE_ADDR;
            data_to_bram <= 8'h00;
            should_read  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_write  <= w_cur_write_nxt;
            addr_to_bram <= w_addr_nxt;
            data_to_bram <= w_data_nxt;
            should_read  <= w_sr_nxt;
            rsp_valid    <= w_capture;
            if (w_capture) rsp_rdata <= data_from_bram;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sound_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_bus_master
// Brief    : Directed and random bench for sound_bus_master with a simple
//            sound-block read/latch model and an in-order scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sound_bus_master;
    import sound_pkg::*;

    localparam logic [15:0] c_IDLE = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_3MHz_en = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic [15:0] addr_to_bram;
    logic [7:0]  data_to_bram;
    logic        should_read;
    logic [7:0]  data_from_bram;
    logic        audiosel;

    int           total = 0;
    int           bad = 0;
    int           n_rsp = 0;
    int           n0;
    int           n_reads;
    bit           en_run = 1'b1;
    logic [1:0]   div = 2'd0;
    snd_bus_req_t bus_q[$];
    logic [7:0]   rsp_q[$];

    logic [15:0]  m_prev_addr = 16'hFFFF;
    logic         m_prev_sr = 1'b0;
    int           m_hi_len = 0;
    bit           m_active = 1'b0;
    bit           m_strobed = 1'b0;
    snd_bus_req_t m_cur;
    logic [7:0]   m_exp;

    bit           r_w;
    logic [15:0]  r_a;
    bit           acc;
    bit           last_t;

    sound_bus_master #(
        .DEPTH     (8),
        .IDLE_ADDR (16'hFFFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_3MHz_en    (clk_3MHz_en),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .busy           (busy),
        .addr_to_bram   (addr_to_bram),
        .data_to_bram   (data_to_bram),
        .should_read    (should_read),
        .data_from_bram (data_from_bram)
    );

    always #5 clk = ~clk;

    // One-clock enable every fourth clock, gated by en_run.
    initial forever begin
        @(posedge clk);
        #1;
        div = div + 2'd1;
        clk_3MHz_en = en_run && (div == 2'd0);
    end

    // Sound-block stand-in: POT/ALLPOT returns the button pattern.
    function automatic logic [7:0] rd_model(input logic [15:0] a);
        return (a == 16'h1828) ? 8'hA5 : (a[7:0] ^ 8'h3C);
    endfunction

    assign data_from_bram = rd_model(addr_to_bram);

    always @(posedge clk or negedge rst) begin
        if (!rst) audiosel <= 1'b0;
        else if (should_read && addr_to_bram == 16'h1840) audiosel <= data_to_bram[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: pops the scoreboard as cycles start and responses arrive.
    always @(negedge clk) begin
        if (!rst) begin
            m_prev_addr = c_IDLE;
            m_prev_sr   = 1'b0;
            m_active    = 1'b0;
            m_strobed   = 1'b0;
            m_hi_len    = 0;
        end else begin
            if (m_prev_addr == c_IDLE && addr_to_bram != c_IDLE) begin
                chk("bus_q_avail", 32'(bus_q.size() != 0), 1);
                if (bus_q.size() != 0) begin
                    m_cur = bus_q.pop_front();
                    chk("cycle_addr", addr_to_bram, m_cur.addr);
                end
                m_active  = 1'b1;
                m_strobed = 1'b0;
            end
            if (should_read && !m_prev_sr) begin
                m_strobed = 1'b1;
                m_hi_len  = 0;
                chk("strobe_is_write", m_cur.write, 1);
                chk("strobe_wdata", data_to_bram, m_cur.wdata);
            end
            if (should_read && m_prev_sr)
                chk("addr_stable_in_strobe", addr_to_bram, m_prev_addr);
            if (should_read) m_hi_len++;
            if (!should_read && m_prev_sr) chk("strobe_len", m_hi_len, 4);
            if (m_prev_addr != c_IDLE && addr_to_bram == c_IDLE && m_active) begin
                chk("strobe_iff_write", m_strobed, m_cur.write);
                m_active = 1'b0;
            end
            if (rsp_valid) begin
                n_rsp++;
                chk("rsp_q_avail", 32'(rsp_q.size() != 0), 1);
                if (rsp_q.size() != 0) begin
                    m_exp = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, m_exp);
                end
            end
            m_prev_addr = addr_to_bram;
            m_prev_sr   = should_read;
        end
    end

    task automatic push_req(input bit w, input logic [15:0] a, input logic [7:0] d);
        snd_bus_req_t e;
        int k;
        k = 0;
        while (!req_ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) chk("push_ready_timeout", req_ready, 1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.write = w;
        e.addr  = a;
        e.wdata = w ? d : 8'h00;
        bus_q.push_back(e);
        if (!w) rsp_q.push_back(rd_model(a));
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            seen = clk_3MHz_en;
        end
        #1;
        if (!seen) chk("tick_timeout", seen, 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", req_ready, 0);
        chk("addr_in_reset", addr_to_bram, c_IDLE);
        chk("sr_in_reset", should_read, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_data", data_to_bram, 8'h00);
        chk("rst_addr", addr_to_bram, c_IDLE);

        // Single write: bus timing in enable periods.
        push_req(1'b1, 16'h182F, 8'h03);
        chk("t1_busy", busy, 1);
        wait_tick();
        chk("t1_addr_tick1", addr_to_bram, 16'h182F);
        chk("t1_sr_tick1", should_read, 0);
        wait_tick();
        for (int i = 0; i < 4; i++) begin
            chk("t1_sr_high", should_read, 1);
            chk("t1_data", data_to_bram, 8'h03);
            @(posedge clk);
            #1;
        end
        chk("t1_sr_low_tick3", should_read, 0);
        chk("t1_addr_hold", addr_to_bram, 16'h182F);
        wait_tick();
        chk("t1_addr_tick4", addr_to_bram, c_IDLE);
        chk("t1_busy_clear", busy, 0);

        // Output latch write, then POT read.
        n0 = n_rsp;
        push_req(1'b1, 16'h1840, 8'h01);
        push_req(1'b0, 16'h1828, 8'h00);
        wait_idle();
        chk("t2_audiosel", audiosel, 1);
        chk("t2_rsp_count", n_rsp - n0, 1);
        chk("t2_rsp_rdata", rsp_rdata, 8'hA5);

        // Fill with the bus frozen, then offer a ninth while full.
        en_run = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++)
            push_req(bit'(i % 2), 16'h1820 + 16'(i), 8'h10 + 8'(i));
        chk("t3_ready_full", req_ready, 0);
        chk("t3_busy", busy, 1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h1808;
        req_wdata = 8'h5E;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_still_full", req_ready, 0);
        chk("t3_frozen_addr", addr_to_bram, c_IDLE);
        en_run = 1'b1;
        acc = 1'b0;
        last_t = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(posedge clk);
            if (req_ready) acc = 1'b1;
            else last_t = clk_3MHz_en;
        end
        #1;
        req_valid = 1'b0;
        begin
            snd_bus_req_t e9;
            e9.write = 1'b1;
            e9.addr  = 16'h1808;
            e9.wdata = 8'h5E;
            bus_q.push_back(e9);
        end
        chk("t4_accepted", acc, 1);
        chk("t4_refused_on_pop_tick", last_t, 1);
        n0 = n_rsp;
        wait_idle();
        chk("t3_rsp_count", n_rsp - n0, 4);

        // Reset in the middle of a strobe, with a read still queued.
        push_req(1'b1, 16'h1821, 8'h77);
        push_req(1'b0, 16'h1812, 8'h00);
        for (int k = 0; k < 100 && !should_read; k++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_in_strobe", should_read, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_sr_async", should_read, 0);
        chk("t5_addr_async", addr_to_bram, c_IDLE);
        chk("t5_busy_async", busy, 0);
        chk("t5_ready_in_reset", req_ready, 0);
        n0 = n_rsp;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_q.delete();
        rsp_q.delete();
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_rsp", n_rsp - n0, 0);
        chk("t5_busy_after", busy, 0);
        chk("t5_addr_after", addr_to_bram, c_IDLE);
        chk("t5_ready_after", req_ready, 1);

        // Random stream against the scoreboard.
        n0 = n_rsp;
        n_reads = 0;
        for (int i = 0; i < 24; i++) begin
            r_w = bit'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: r_a = 16'h1820 + 16'($urandom_range(0, 15));
                1: r_a = 16'h1810 + 16'($urandom_range(0, 15));
                2: r_a = 16'h1840;
                default: r_a = 16'h1808;
            endcase
            if (!r_w) n_reads++;
            push_req(r_w, r_a, 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        chk("t6_rsp_count", n_rsp - n0, n_reads);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
